// File: rtl/seg_display_pkg.sv
// Shared types, segment constants and helpers for the multiplexed
// 7-segment display stage.
//   conv_state_t : binary-to-BCD conversion FSM states
//   SEG_BLANK    : all segments off (active low)
//   SEG_DASH     : only segment g lit
//   bcd_to_seg() : BCD nibble -> active-low {g,f,e,d,c,b,a}
//   pow10()      : 10^n, used to size the overflow threshold
package seg_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < 19; i++) begin
            if (i < n) r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_display_mux_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one bit per cycle.
//   clk, rst : clock, asynchronous active-low reset
//   start    : capture bin and begin a conversion (accepted in IDLE or DONE)
//   bin      : binary input
//   busy     : conversion in progress (stays high across back-to-back starts)
//   done     : high for the single DONE cycle; bcd/ovf are valid then
//   bcd      : low NUM_DIGITS BCD digits of the result
//   ovf      : captured value exceeds 10^NUM_DIGITS - 1
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | VALUE_W add-3/shift iterations, counted down to zero
// DONE  | result valid for one cycle; restart directly if start is high
module bin2bcd_seq
    import seg_display_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf
);

    // ceil(VALUE_W*log10(2)) <= (VALUE_W+2)/3, so the accumulator never
    // loses a carry even when the display has fewer digits.
    localparam int FULL_DIGITS = (VALUE_W + 2) / 3;
    localparam int ACC_DIGITS  = (FULL_DIGITS > NUM_DIGITS) ? FULL_DIGITS : NUM_DIGITS;
    localparam int ACC_W       = 4 * ACC_DIGITS;
    localparam int CNT_W       = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(VALUE_W - 1);
    localparam logic [63:0]      MAX_SHOWN = pow10(NUM_DIGITS) - 64'd1;

    conv_state_t        state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [VALUE_W-1:0] sh;
    logic [CNT_W-1:0]   cnt;

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < ACC_DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
    end

    assign bcd = acc[4*NUM_DIGITS-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
            sh    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SHIFT: begin
                    {acc, sh} <= {acc_adj, sh} << 1;
                    if (cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        sh    <= bin;
                        acc   <= '0;
                        cnt   <= CNT_LAST;
                        ovf   <= (64'(bin) > MAX_SHOWN);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/seg_display_mux.sv
// N-digit multiplexed 7-segment driver with sequential BCD conversion,
// per-digit blink, leading-zero blanking and overflow dashes.
//   clk, rst  : clock, asynchronous active-low reset
//   value     : binary value, captured on load
//   load      : single-cycle capture strobe (queued one deep while busy)
//   blink_en  : per-digit blink enable, bit 0 = rightmost digit
//   blank_lz  : blank leading zeros (digit 0 always shown)
//   dp        : per-digit decimal point, active high
//   busy      : BCD conversion in progress
//   seg       : segments {g,f,e,d,c,b,a}, active low, registered
//   dp_n      : decimal point, active low, registered
//   an        : anodes, active low, registered; an[0] = rightmost digit
module seg_display_mux
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int CLK_HZ     = 100000000,
    parameter int REFRESH_HZ = 500,
    parameter int BLINK_HZ   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] blink_en,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp,
    output logic                  busy,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int DWELL_RAW  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int DWELL      = (DWELL_RAW < 1) ? 1 : DWELL_RAW;
    localparam int BLINK_RAW  = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLINK_HALF = (BLINK_RAW < 1) ? 1 : BLINK_RAW;
    localparam int DWELL_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic                    conv_start;
    logic                    conv_done;
    logic [VALUE_W-1:0]      conv_bin;
    logic [4*NUM_DIGITS-1:0] conv_bcd;
    logic                    conv_ovf;
    logic [VALUE_W-1:0]      pend_val;
    logic                    pend_vld;
    logic [4*NUM_DIGITS-1:0] disp_bcd;
    logic                    disp_ovf;

    logic [DWELL_W-1:0]      dwell_cnt;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    blink_phase;
    logic [IDX_W-1:0]        digit_idx;

    logic [3:0]              cur_nib;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    zero_run;
    logic                    blink_off;
    logic [6:0]              seg_next;
    logic                    dp_n_next;
    logic [NUM_DIGITS-1:0]   an_next;

    // A load during DONE (or a queued one) restarts the converter without
    // dropping busy; a fresh load beats the older pending value.
    assign conv_start = (!busy && load) || (conv_done && (load || pend_vld));
    assign conv_bin   = load ? value : pend_val;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_val <= '0;
            pend_vld <= 1'b0;
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else begin
            if (conv_done) begin
                pend_vld <= 1'b0;
                disp_bcd <= conv_bcd;
                disp_ovf <= conv_ovf;
            end else if (busy && load) begin
                pend_val <= value;
                pend_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_cnt   <= '0;
            digit_idx   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (dwell_cnt == DWELL_LAST) begin
                dwell_cnt <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // lz_blank[i]: digit i and every digit above it are zero.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_bcd[4*i +: 4] == 4'd0);
            if (i > 0) lz_blank[i] = zero_run;
        end
    end

    always_comb begin
        cur_nib   = disp_bcd[4*digit_idx +: 4];
        blink_off = blink_phase && blink_en[digit_idx];
        an_next   = '1;
        an_next[digit_idx] = 1'b0;
        dp_n_next = ~dp[digit_idx];
        if (blink_off) begin
            seg_next  = SEG_BLANK;
            dp_n_next = 1'b1;
        end else if (disp_ovf) begin
            seg_next = SEG_DASH;
        end else if (blank_lz && lz_blank[digit_idx]) begin
            seg_next = SEG_BLANK;
        end else begin
            seg_next = bcd_to_seg(cur_nib);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an   <= '1;
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
        end else begin
            an   <= an_next;
            seg  <= seg_next;
            dp_n <= dp_n_next;
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: reset/scan sequence, a table of display
// vectors, back-to-back loads, blink/dp and reset during conversion.
module tb_seg_display_mux;

    localparam int ND = 4;
    localparam int VW = 14;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S9 = 7'h10;
    localparam logic [6:0] SB = 7'h7F, SD = 7'h3F;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [VW-1:0] value = '0;
    logic          load = 1'b0;
    logic [ND-1:0] blink_en = '0;
    logic          blank_lz = 1'b1;
    logic [ND-1:0] dp = '0;
    logic          busy;
    logic [6:0]    seg;
    logic          dp_n;
    logic [ND-1:0] an;

    int errors = 0;
    int checks = 0;
    int cyc;

    typedef struct {
        logic [VW-1:0] val;
        logic          lz;
        logic [27:0]   exp;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t        vecs[12];
    logic [27:0] exp_q[$];

    seg_display_mux #(
        .NUM_DIGITS (ND),
        .VALUE_W    (VW),
        .CLK_HZ     (1000),
        .REFRESH_HZ (50),
        .BLINK_HZ   (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .blink_en (blink_en),
        .blank_lz (blank_lz),
        .dp       (dp),
        .busy     (busy),
        .seg      (seg),
        .dp_n     (dp_n),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release; drives the blink-phase model.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int digit_of(input logic [ND-1:0] a);
        int d;
        logic [ND-1:0] m;
        d = -1;
        for (int i = 0; i < ND; i++) begin
            m = '1;
            m[i] = 1'b0;
            if (a == m) d = i;
        end
        return d;
    endfunction

    task automatic check_disp(input logic [27:0] exp, input string name);
        int d;
        logic [6:0] e;
        d = digit_of(an);
        check("an_onehot", 32'(d >= 0), 32'd1);
        if (d >= 0) begin
            e = exp[d*7 +: 7];
            check(name, 32'(seg), 32'(e));
        end
    endtask

    task automatic do_load(input logic [VW-1:0] v);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        logic [27:0] prev, cur, exp42, exp100, exp305, exp_zero;
        logic [ND-1:0] ea;
        int nb, d;
        logic ph, blinked;

        vecs[0]  = '{14'd1234,  1'b1, {S1, S2, S3, S4}};
        vecs[1]  = '{14'd7,     1'b1, {SB, SB, SB, S7}};
        vecs[2]  = '{14'd7,     1'b0, {S0, S0, S0, S7}};
        vecs[3]  = '{14'd12000, 1'b1, {SD, SD, SD, SD}};
        vecs[4]  = '{14'd9999,  1'b1, {S9, S9, S9, S9}};
        vecs[5]  = '{14'd0,     1'b0, {S0, S0, S0, S0}};
        vecs[6]  = '{14'd0,     1'b1, {SB, SB, SB, S0}};
        vecs[7]  = '{14'd305,   1'b1, {SB, S3, S0, S5}};
        vecs[8]  = '{14'd5060,  1'b1, {S5, S0, S6, S0}};
        vecs[9]  = '{14'd10000, 1'b0, {SD, SD, SD, SD}};
        vecs[10] = '{14'd16383, 1'b1, {SD, SD, SD, SD}};
        vecs[11] = '{14'd1000,  1'b1, {S1, S0, S0, S0}};
        exp_zero = {SB, SB, SB, S0};
        exp42    = {SB, SB, S4, S2};
        exp100   = {SB, S1, S0, S0};
        exp305   = {SB, S3, S0, S5};

        // Reset state and first scan pass.
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp_n", 32'(dp_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        #1;
        check("rel_an", 32'(an), 32'hF);
        check("rel_seg", 32'(seg), 32'h7F);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ea = ~(4'b0001 << ((k - 1) / 5));
            check("scan_an", 32'(an), 32'(ea));
            check_disp(exp_zero, "scan_seg");
        end

        // Table of display vectors.
        prev = exp_zero;
        for (int i = 0; i < 12; i++) begin
            do_load(vecs[i].val);
            exp_q.push_back(vecs[i].exp);
            nb = 0;
            while (busy === 1'b1 && nb < 100) begin
                check_disp(prev, "hold_seg");
                nb++;
                @(negedge clk);
            end
            check("busy_len", 32'(nb), 32'd15);
            blank_lz = vecs[i].lz;
            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            @(negedge clk);
            repeat (20) begin
                check_disp(cur, "disp_seg");
                check("disp_dp_n", 32'(dp_n), 32'd1);
                @(negedge clk);
            end
            prev = cur;
        end

        // Back-to-back: 42, then 100 and 305 queued while busy.
        blank_lz = 1'b1;
        do_load(14'd42);
        exp_q.push_back(exp42);
        cur = prev;
        for (int k = 0; k <= 50; k++) begin
            if (k == 16 || k == 31) begin
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            end
            check("b2b_busy", 32'(busy), 32'(k < 30));
            check_disp(cur, "b2b_seg");
            if (k == 2) begin
                value = 14'd100; load = 1'b1;
                exp_q.push_back(exp100);
            end else if (k == 5) begin
                value = 14'd305; load = 1'b1;
                exp_q[exp_q.size() - 1] = exp305;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // Blink on digit 0, decimal point on digit 1.
        blink_en = 4'b0001;
        dp       = 4'b0010;
        @(negedge clk);
        for (int k = 0; k < 200; k++) begin
            d  = digit_of(an);
            ph = (((cyc - 1) / 50) % 2) == 1;
            blinked = ph && (d == 0);
            check("blink_an_onehot", 32'(d >= 0), 32'd1);
            if (d >= 0) begin
                check("blink_seg", 32'(seg), blinked ? 32'h7F : 32'(exp305[d*7 +: 7]));
                check("blink_dp_n", 32'(dp_n), 32'(d != 1));
            end
            @(negedge clk);
        end
        blink_en = '0;
        dp       = '0;

        // Reset in the middle of a conversion.
        do_load(14'd1234);
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_dp_n", 32'(dp_n), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            check("post_rst_busy", 32'(busy), 32'd0);
            check_disp(exp_zero, "post_rst_seg");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Parametrised N-digit multiplexed 7-segment driver; next-generation display stage for the reaction game.
- Latches a binary value and converts it to BCD sequentially (double-dabble).
- Scans digits at a programmable refresh rate, with per-digit blink, leading-zero blanking and overflow indication.
- Sits between game logic and board pins; contains its own tick generators, so no external divided clocks are needed.

Parameters:
- NUM_DIGITS, 4: number of digits/anodes (1..8).
- VALUE_W, 14: binary input width.
- CLK_HZ, 100000000: clk frequency.
- REFRESH_HZ, 500: full-display refresh rate; per-digit dwell is CLK_HZ/(REFRESH_HZ*NUM_DIGITS) cycles.
- BLINK_HZ, 2: blink rate; blink phase toggles every CLK_HZ/(2*BLINK_HZ) cycles.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-low reset.
- value  in  VALUE_W  unsigned binary value to display.
- load  in  1  single-cycle strobe; capture value.
- blink_en  in  NUM_DIGITS  per-digit blink enable (bit 0 = rightmost digit).
- blank_lz  in  1  when 1, blank leading zeros.
- dp  in  NUM_DIGITS  per-digit decimal point, active high.
- busy  out  1  BCD conversion in progress.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp_n  out  1  decimal point, active low.
- an  out  NUM_DIGITS  anodes, active low; an[0] = rightmost digit.

Behaviour:
- Reset (rst=0, asynchronous):
  - seg=7'h7F, dp_n=1, an all 1, busy=0.
  - Displayed BCD register = 0; overflow flag = 0; pending = 0.
  - Digit index = 0; both tick counters = 0; blink phase = 0.
  - Effect is immediate, including mid-conversion; the conversion is abandoned.
- Conversion FSM states IDLE, SHIFT, DONE:
  - IDLE with load=1: capture value; set ovf = (value > 10^NUM_DIGITS - 1); go to SHIFT; busy=1 from the next cycle.
  - SHIFT: exactly VALUE_W iterations. Each iteration adds 3 to every BCD nibble >= 5, then shifts left by 1. Then go to DONE.
  - DONE (1 cycle): copy BCD result and ovf into the display registers atomically; busy=0 next cycle; return to IDLE.
  - Load-to-display latency: VALUE_W+2 cycles. The old value stays displayed until DONE.
- load while busy:
  - value is stored in a one-deep pending register; the latest load wins.
  - When the current conversion reaches DONE, a new conversion starts immediately from the pending value, and busy stays 1.
- load in the same cycle as DONE is treated as pending.
- Scan:
  - Dwell counter counts 0..DWELL-1; at wrap, digit index increments and wraps from NUM_DIGITS-1 to 0.
  - an, seg and dp_n are registered and update 1 cycle after the index changes.
  - Exactly one an bit is low at any time after reset.
- Blink: a free-running counter toggles blink phase. When phase=1 and blink_en[i]=1, digit i shows seg=7'h7F and dp_n=1, while its anode still scans.
- Leading-zero blanking: with blank_lz=1, digit i>0 is blanked (seg=7'h7F) if it and all higher digits are zero. Digit 0 is never blanked, so value 0 shows a single 0.
- Overflow: when the displayed ovf=1, every digit shows a dash (seg=7'b0111111), ignoring blank_lz. Blink and dp still apply.
- Segment codes (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any nibble >9 (unreachable) shows a dash.
- Dwell and blink periods are computed with integer division, minimum 1.

Decomposition:
- Package seg_display_pkg:
  - conv_state_t enum (IDLE, SHIFT, DONE).
  - Constants SEG_BLANK=7'h7F and SEG_DASH=7'b0111111.
  - Function bcd_to_seg(nibble) returning 7 bits.
  - Function pow10(n) for the overflow threshold.
- Sub-module bin2bcd_seq: the FSM plus shift register, with ports clk, rst, start, bin, busy, done, bcd, ovf.
- The top of this block holds the pending register, tick counters, scan and output registers.

Test Plan (sim parameters CLK_HZ=1000, REFRESH_HZ=50, BLINK_HZ=10, giving dwell 5 cycles and blink toggle 50 cycles):
- Reset released -> an=4'b1111 and seg=7'h7F for 1 cycle, then an cycles 1110, 1101, 1011, 0111 every 5 cycles, with seg=1000000 on an[0] and 7'h7F elsewhere when blank_lz=1.
- load value=1234 -> busy high for 15 cycles; seg shows 0011001 on an[0], 0110000 on an[1], 0100100 on an[2], 1111001 on an[3]; the old display holds during busy.
- load 7, blank_lz=1 -> only an[0] shows 1111000; other digits show 7'h7F. With blank_lz=0, the other digits show 1000000.
- load 12000 -> all four digits show 0111111. Then load 9999 -> all digits show 0010000.
- load 42, then load 100 and load 305 while busy -> 42 is displayed, then back-to-back conversion of 305 with busy continuous; 100 is never displayed.
- blink_en=4'b0001 with dp=4'b0010 -> digit 0 is dark for 50 of every 100 cycles; dp_n=0 only while an[1]=0.
- rst asserted at cycle 5 of a conversion -> all outputs return to reset values immediately; after release, the display shows 0 and busy=0.
